// File: rtl/arb_mux.sv
// arb_mux: N-channel registered multiplexor with valid/ready handshaking.
// Arbitrates among requesting channels (round-robin or fixed priority) and
// registers the winning word into a single output stage.
module arb_mux #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = 1,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_any;
    logic             w_xfer;
    logic [SELW-1:0]  w_gnt;
    logic [SELW-1:0]  w_base;
    logic [WIDTH-1:0] w_gnt_data;

    // Output stage accepts a word when empty or being drained this cycle
    assign w_load = !r_valid || out_ready;

    // Fixed priority is a round-robin scan that always starts at channel 0
    assign w_base = (RR != 0) ? r_ptr : '0;

    // Grant search: first requesting channel scanning upward from w_base, wrapping at N-1
    always_comb begin
        logic [SELW:0] idx;
        w_any = 1'b0;
        w_gnt = '0;
        idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = {1'b0, w_base} + (SELW+1)'(k);
            if (idx >= (SELW+1)'(N)) begin
                idx = idx - (SELW+1)'(N);
            end
            if (!w_any && in_valid[idx[SELW-1:0]]) begin
                w_any = 1'b1;
                w_gnt = idx[SELW-1:0];
            end
        end
    end

    // Reset gating keeps in_ready low for the whole reset assertion
    assign w_xfer = w_load && w_any && !rst;

    // Data mux for the granted channel
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_gnt == SELW'(i)) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept for the granted channel only
    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_gnt_data;
                r_sel   <= w_gnt;
                if (RR != 0) begin
                    r_ptr <= (w_gnt == SELW'(N - 1)) ? '0 : w_gnt + SELW'(1);
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
